// File: rtl/risc_multicycle_sequencer_pkg.sv
// rtl/risc_multicycle_sequencer_pkg.sv - shared state encodings for the multi-cycle sequencer
package risc_multicycle_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } seq_state_t;

  function automatic logic is_terminal(input seq_state_t s);
    return (s == S_HALT) || (s == S_ERROR);
  endfunction

endpackage

// File: rtl/risc_multicycle_sequencer_if.sv
// rtl/risc_multicycle_sequencer_if.sv - instruction and data memory req/ack bundle
interface risc_multicycle_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/risc_multicycle_sequencer_req_wait_timer.sv
// rtl/risc_multicycle_sequencer_req_wait_timer.sv - bounded wait for a request's ack
module req_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic req,
  input  logic ack,
  output logic expired
);
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CW-1:0] remaining;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= CW'(MAX_WAIT);
    end else if (clear) begin
      remaining <= CW'(MAX_WAIT);
    end else if (req && !ack && remaining != '0) begin
      remaining <= remaining - CW'(1);
    end
  end

  // Fires in the last permitted waiting cycle so the request is gone on the next one.
  assign expired = (MAX_WAIT != 0) && req && !ack && (remaining == CW'(1));

endmodule

// File: rtl/risc_multicycle_sequencer.sv
// rtl/risc_multicycle_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB control sequencer with timeout and halt
module risc_multicycle_sequencer
  import risc_multicycle_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 16,
  parameter int                CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  risc_multicycle_sequencer_if.master mem,
  output logic [DATA_W-1:0]          instr,
  input  logic                       dec_mem_read,
  input  logic                       dec_mem_write,
  input  logic                       dec_reg_write,
  input  logic                       dec_halt,
  input  logic [ADDR_W-1:0]          pc_next,
  output logic [ADDR_W-1:0]          pc,
  output logic [DATA_W-1:0]          mdr,
  output logic                       rf_we,
  output logic [CNT_W-1:0]           instret,
  output logic                       halted,
  output logic                       bus_error,
  output logic [STATE_W-1:0]         state
);

  seq_state_t cur_state, nxt_state;
  logic       fetch_pending;
  logic       imem_req_i, dmem_req_i, dmem_we_i, rf_we_i;
  logic       retire;
  logic       timer_clear, timer_ack, expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    imem_req_i = 1'b0;
    dmem_req_i = 1'b0;
    dmem_we_i  = 1'b0;
    rf_we_i    = 1'b0;
    retire     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        // Once raised, the fetch request stays up even if run drops.
        if (run || fetch_pending) begin
          imem_req_i = 1'b1;
          if (mem.imem_ack)  nxt_state = S_DECODE;
          else if (expired)  nxt_state = S_ERROR;
        end
      end
      S_DECODE: nxt_state = dec_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (dec_mem_read || dec_mem_write) begin
          nxt_state = S_MEM;
        end else if (dec_reg_write) begin
          nxt_state = S_WB;
        end else begin
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req_i = 1'b1;
        dmem_we_i  = dec_mem_write;
        if (mem.dmem_ack) begin
          if (dec_mem_write) begin
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end else if (expired) begin
          nxt_state = S_ERROR;
        end
      end
      S_WB: begin
        rf_we_i   = 1'b1;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_HALT:  nxt_state = S_HALT;
      S_ERROR: nxt_state = S_ERROR;
      default: nxt_state = S_ERROR;
    endcase
  end

  assign timer_ack   = (cur_state == S_MEM) ? mem.dmem_ack : mem.imem_ack;
  assign timer_clear = (nxt_state != cur_state) &&
                       ((nxt_state == S_FETCH) || (nxt_state == S_MEM));

  req_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .req     (imem_req_i | dmem_req_i),
    .ack     (timer_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pending <= 1'b0;
      pc            <= RESET_PC;
      instr         <= '0;
      mdr           <= '0;
      instret       <= '0;
    end else begin
      fetch_pending <= imem_req_i && (nxt_state == S_FETCH);
      if (imem_req_i && mem.imem_ack) instr <= mem.imem_rdata;
      if (dmem_req_i && !dmem_we_i && mem.dmem_ack) mdr <= mem.dmem_rdata;
      if (retire) begin
        pc      <= pc_next;
        instret <= instret + CNT_W'(1);
      end
    end
  end

  // Reset is folded into the strobes so requests vanish the moment it asserts.
  assign mem.imem_req  = imem_req_i & ~reset;
  assign mem.dmem_req  = dmem_req_i & ~reset;
  assign mem.dmem_we   = dmem_we_i & ~reset;
  assign mem.imem_addr = pc;
  assign rf_we         = rf_we_i & ~reset;
  assign halted        = (cur_state == S_HALT);
  assign bus_error     = (cur_state == S_ERROR);
  assign state         = cur_state;

  logic unused_terminal;
  assign unused_terminal = is_terminal(cur_state);

endmodule
